// File: rtl/signal_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | signal_sweep_ctrl                                                          |
// | Raster sweep of the signal grid: gathers centre + 8 neighbours per cell,   |
// | hands them to the next-signal datapath and writes the ping-pong buffer.    |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module signal_sweep_ctrl #(
   parameter int GRID_W      = 16,
   parameter int GRID_H      = 16,
   parameter int SIGNAL_bits = 16,
   parameter int ADDR_bits   = 8,
   localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
   localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     buf_sel,
   output logic                     rd_en,
   output logic [ADDR_bits-1:0]     rd_addr,
   input  logic [SIGNAL_bits-1:0]   rd_data,
   output logic [XW-1:0]            write_x,
   output logic [YW-1:0]            write_y,
   output logic                     cell_strobe,
   output logic [SIGNAL_bits-1:0]   ns_cur,
   output logic [8*SIGNAL_bits-1:0] ns_surrounding,
   input  logic [SIGNAL_bits-1:0]   ns_new,
   output logic                     wr_en,
   output logic [ADDR_bits-1:0]     wr_addr,
   output logic [SIGNAL_bits-1:0]   wr_data
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_CAPTURE = 3'd2,
      S_WRITE   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                 state;
   logic [XW-1:0]          x;
   logic [YW-1:0]          y;
   logic [3:0]             k;

   // Capture pipeline: read issued for step cap_k lands one cycle later.
   logic                   cap_act;
   logic                   cap_valid;
   logic [3:0]             cap_k;
   logic [2:0]             cap_d;
   logic [SIGNAL_bits-1:0] centre;
   logic [SIGNAL_bits-1:0] slot [8];
   logic [SIGNAL_bits-1:0] centre_nxt;
   logic [SIGNAL_bits-1:0] slot_nxt [8];
   logic [8*SIGNAL_bits-1:0] sur_nxt;

   int                     dx, dy, nx, ny;
   logic                   on_grid;
   logic                   last_col, last_cell;

   // Step k: 0 = centre, 1..8 = neighbours NW,N,NE,W,E,SW,S,SE.
   always_comb begin
      dx = 0;
      dy = 0;
      case (k)
         4'd1:    begin dx = -1; dy = -1; end
         4'd2:    begin dx =  0; dy = -1; end
         4'd3:    begin dx =  1; dy = -1; end
         4'd4:    begin dx = -1; dy =  0; end
         4'd5:    begin dx =  1; dy =  0; end
         4'd6:    begin dx = -1; dy =  1; end
         4'd7:    begin dx =  0; dy =  1; end
         4'd8:    begin dx =  1; dy =  1; end
         default: begin dx =  0; dy =  0; end
      endcase
      nx      = int'(x) + dx;
      ny      = int'(y) + dy;
      on_grid = (nx >= 0) && (nx < GRID_W) && (ny >= 0) && (ny < GRID_H);
   end

   assign rd_en   = (state == S_FETCH) && on_grid;
   assign rd_addr = rd_en ? ADDR_bits'(ny * GRID_W + nx) : '0;

   assign cap_d = 3'(cap_k - 4'd1);

   always_comb begin
      centre_nxt = centre;
      for (int i = 0; i < 8; i++) slot_nxt[i] = slot[i];
      if (cap_act) begin
         if (cap_k == 4'd0) centre_nxt = rd_data;
         else               slot_nxt[cap_d] = cap_valid ? rd_data : centre;
      end
      sur_nxt = '0;
      for (int i = 0; i < 8; i++) sur_nxt[i*SIGNAL_bits +: SIGNAL_bits] = slot_nxt[i];
   end

   assign last_col  = (x == XW'(GRID_W - 1));
   assign last_cell = last_col && (y == YW'(GRID_H - 1));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state          <= S_IDLE;
         x              <= '0;
         y              <= '0;
         k              <= '0;
         cap_act        <= 1'b0;
         cap_valid      <= 1'b0;
         cap_k          <= '0;
         centre         <= '0;
         for (int i = 0; i < 8; i++) slot[i] <= '0;
         ns_cur         <= '0;
         ns_surrounding <= '0;
         buf_sel        <= 1'b0;
      end else begin
         centre <= centre_nxt;
         for (int i = 0; i < 8; i++) slot[i] <= slot_nxt[i];
         cap_act   <= (state == S_FETCH);
         cap_k     <= k;
         cap_valid <= rd_en;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_FETCH;
                  x     <= '0;
                  y     <= '0;
                  k     <= '0;
               end
            end
            S_FETCH: begin
               if (k == 4'd8) begin
                  k     <= '0;
                  state <= S_CAPTURE;
               end else begin
                  k <= k + 4'd1;
               end
            end
            S_CAPTURE: begin
               // Final slot lands on this edge, so publish the next-state view.
               ns_cur         <= centre_nxt;
               ns_surrounding <= sur_nxt;
               state          <= S_WRITE;
            end
            S_WRITE: begin
               if (last_cell) begin
                  x       <= '0;
                  y       <= '0;
                  buf_sel <= ~buf_sel;
                  state   <= S_DONE;
               end else if (last_col) begin
                  x     <= '0;
                  y     <= y + 1'b1;
                  state <= S_FETCH;
               end else begin
                  x     <= x + 1'b1;
                  state <= S_FETCH;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (state == S_FETCH) || (state == S_CAPTURE) || (state == S_WRITE);
   assign done        = (state == S_DONE);
   assign wr_en       = (state == S_WRITE);
   assign cell_strobe = (state == S_WRITE);
   assign write_x     = x;
   assign write_y     = y;
   assign wr_addr     = ADDR_bits'(int'(y) * GRID_W + int'(x));
   assign wr_data     = wr_en ? ns_new : '0;

endmodule
`default_nettype wire

// File: tb/tb_signal_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_signal_sweep_ctrl                                                       |
// | Self-checking bench: 4x4 grid, ping-pong memory model, ns_new = ns_cur+1.  |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_signal_sweep_ctrl;

   localparam int W = 4;
   localparam int H = 4;
   localparam int N = W * H;
   localparam int CELL_CYC = 11;

   logic          Clk = 1'b0;
   logic          Reset_n;
   logic          start;
   logic          busy, done, buf_sel, rd_en, cell_strobe, wr_en;
   logic [7:0]    rd_addr, wr_addr;
   logic [15:0]   rd_data = '0;
   logic [1:0]    write_x, write_y;
   logic [15:0]   ns_cur, ns_new, wr_data;
   logic [127:0]  ns_surrounding;

   logic [15:0]   mem      [2][N];
   logic [15:0]   load_img [2][N];
   logic          load_en;

   logic [15:0]   model    [2][N];
   int            sel;
   int            checks   = 0;
   int            failures = 0;

   int dxt [9] = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
   int dyt [9] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};

   signal_sweep_ctrl #(
      .GRID_W(W), .GRID_H(H), .SIGNAL_bits(16), .ADDR_bits(8)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .start(start),
      .busy(busy), .done(done), .buf_sel(buf_sel),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .write_x(write_x), .write_y(write_y), .cell_strobe(cell_strobe),
      .ns_cur(ns_cur), .ns_surrounding(ns_surrounding), .ns_new(ns_new),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   assign ns_new = ns_cur + 16'd1;

   always #5 Clk = ~Clk;

   // Ping-pong memory: read buffer buf_sel, write buffer !buf_sel.
   always @(posedge Clk) begin
      if (load_en) mem <= load_img;
      else begin
         if (rd_en) rd_data <= mem[buf_sel][rd_addr[3:0]];
         if (wr_en) mem[~buf_sel][wr_addr[3:0]] <= wr_data;
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [185:0] all_outs();
      return {busy, done, buf_sel, rd_en, rd_addr, write_x, write_y, cell_strobe,
              ns_cur, ns_surrounding, wr_en, wr_addr, wr_data};
   endfunction

   function automatic bit in_grid(int px, int py);
      return (px >= 0) && (px < W) && (py >= 0) && (py < H);
   endfunction

   function automatic logic [127:0] exp_sur(int b, int cx, int cy);
      logic [127:0] v;
      int px, py;
      v = '0;
      for (int d = 0; d < 8; d++) begin
         px = cx + dxt[d+1];
         py = cy + dyt[d+1];
         v[d*16 +: 16] = in_grid(px, py) ? model[b][py*W + px] : model[b][cy*W + cx];
      end
      return v;
   endfunction

   task automatic load_grids(input bit seed_corner);
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < N; i++) model[b][i] = 16'($urandom);
      if (seed_corner) model[0][0] = 16'h0100;
      load_img = model;
      @(negedge Clk); load_en = 1'b1;
      @(negedge Clk); load_en = 1'b0;
   endtask

   // Entered at a negedge with start already high and the DUT idle.
   task automatic run_sweep(input bit hold, input bit noise);
      int c, ph, cx, cy, px, py;
      bit on;
      logic [15:0] e;
      @(negedge Clk);
      for (int t = 0; t < N * CELL_CYC; t++) begin
         start = hold;
         if (noise && ($urandom_range(0, 5) == 0)) start = 1'b1;
         c  = t / CELL_CYC;
         ph = t % CELL_CYC;
         cx = c % W;
         cy = c / W;
         check("busy", busy, 1);
         check("buf_sel_sweep", buf_sel, sel);
         if (ph <= 8) begin
            px = cx + dxt[ph];
            py = cy + dyt[ph];
            on = in_grid(px, py);
            check("rd_en", rd_en, on);
            if (on) check("rd_addr", rd_addr, py*W + px);
            check("wr_en_fetch", wr_en, 0);
         end else if (ph == 9) begin
            check("rd_en_capture", rd_en, 0);
            check("wr_en_capture", wr_en, 0);
         end else begin
            e = model[sel][c] + 16'd1;
            check("wr_en", wr_en, 1);
            check("cell_strobe", cell_strobe, 1);
            check("rd_en_write", rd_en, 0);
            check("wr_addr", wr_addr, c);
            check("write_x", write_x, cx);
            check("write_y", write_y, cy);
            check("ns_cur", ns_cur, model[sel][c]);
            check("ns_surrounding", ns_surrounding, exp_sur(sel, cx, cy));
            check("wr_data", wr_data, e);
         end
         if (ph != 10) begin
            check("wr_data_idle", wr_data, 0);
            check("cell_strobe_idle", cell_strobe, 0);
         end
         @(negedge Clk);
      end
      check("done_pulse", done, 1);
      check("busy_done", busy, 0);
      check("wr_en_done", wr_en, 0);
      check("buf_sel_toggle", buf_sel, 1 - sel);
      for (int i = 0; i < N; i++) model[1-sel][i] = model[sel][i] + 16'd1;
      sel = 1 - sel;
      start = hold | noise;
      @(negedge Clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      if (!hold) start = 1'b0;
   endtask

   initial begin
      Reset_n = 1'b0;
      start   = 1'b0;
      load_en = 1'b0;
      sel     = 0;
      repeat (3) @(negedge Clk);
      check("reset_outs", all_outs(), '0);
      Reset_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clk);
         check("idle_outs", all_outs(), '0);
      end

      // Single sweep with stray start pulses while busy and in DONE.
      load_grids(1'b1);
      start = 1'b1;
      run_sweep(1'b0, 1'b1);
      @(negedge Clk);
      check("start_ignored_done", busy, 0);

      // Start held high: two back-to-back sweeps, first reads buffer 1.
      start = 1'b1;
      run_sweep(1'b1, 1'b0);
      run_sweep(1'b1, 1'b0);
      start = 1'b0;
      @(negedge Clk);
      check("held_stop", busy, 0);

      // Reset 60 cycles into a sweep (buf_sel is 1 beforehand).
      check("buf_sel_pre_reset", buf_sel, 1);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      repeat (60) @(negedge Clk);
      Reset_n = 1'b0;
      #1;
      check("midsweep_reset_outs", all_outs(), '0);
      repeat (3) begin
         @(negedge Clk);
         check("wr_en_in_reset", wr_en, 0);
      end
      Reset_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clk);
         check("no_activity_after_reset", {wr_en, busy, buf_sel}, 0);
      end

      // Fresh sweep after the abandoned one.
      sel = 0;
      load_grids(1'b0);
      start = 1'b1;
      run_sweep(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
